uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
- Parametrised, handshaked UART transmitter; next generation of the fixed 8N1 transmitter datapath/controller pair.
- Generalised in data width, parity mode and stop-bit count.
- Runtime baud divisor instead of a hard-coded tick compare.
- Sits between a byte-stream producer (valid/ready) and the serial pin `tx`.

Parameters:
- DATA_BITS, 8, payload bits per frame (5..9), sent LSB first.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- baud_div  in  DIV_W  clock cycles per serial bit; sampled at frame acceptance.
- in_data  in  DATA_BITS  payload to transmit.
- in_valid  in  1  producer has a payload.
- in_ready  out  1  transmitter can accept a payload this cycle.
- tx  out  1  serial line; idle high.
- busy  out  1  a frame is in progress (any state other than IDLE).
- frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Reset: synchronous, active-high, applied on the `clk` edge while `rst` = 1. After reset: state = IDLE, tx = 1, in_ready = 1, busy = 0, frame_done = 0, all counters 0. Reset mid-frame aborts the frame immediately; tx returns high on the next edge and no frame_done pulse is produced.
- Handshake:
  - Transfer occurs on a rising edge where in_valid && in_ready.
  - in_ready = 1 only in IDLE.
  - At transfer: in_data is latched into the shift register and baud_div into the divisor register (baud_div = 0 is treated as 1).
  - Changes to in_data/baud_div after transfer do not affect the frame in flight.
- States: IDLE -> START -> DATA -> PARITY (skipped when PARITY_MODE = 0) -> STOP -> IDLE.
- Bit timing: each bit holds tx constant for exactly D cycles (D = latched divisor). A bit-cycle counter counts 0..D-1 and raises bit_tick when it reaches D-1, then clears.
- Per-state transitions:
  - IDLE: tx = 1. On transfer, go to START; the counter clears.
  - START: tx = 0. On bit_tick, go to DATA with bit index 0.
  - DATA: tx = shift_reg[0]. On bit_tick, shift right and increment the index. After index DATA_BITS-1, go to PARITY or STOP.
  - PARITY: tx = XOR of the latched payload for even parity; its complement for odd. Parity is computed at latch time, not from the shifted register.
  - STOP: tx = 1 for STOP_BITS*D cycles. frame_done = 1 on the final cycle. Next state is IDLE.
- Latency: first start-bit cycle on tx is the cycle after the transfer edge.
- Frame length: (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) * D cycles. Minimum gap between frames is 1 IDLE cycle with tx = 1.
- Back-to-back: in_valid held high is accepted on the first IDLE cycle after frame_done.
- Simultaneous rst and in_valid: rst wins; no transfer.
- Counter widths: bit-cycle counter is DIV_W bits; bit index is clog2(DATA_BITS+1) bits; stop counter is 1 bit.
- Wrap-around of the bit-cycle counter never occurs: it clears on bit_tick.
- Outputs are registered (tx driven from a flop) so the pin is glitch-free.

Decomposition:
- Shared package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - parity_mode_t constants (PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2).
  - Helper function computing parity of a DATA_BITS vector.
- One sub-module: uart_baud_gen. Parametrised by DIV_W; inputs clk, rst, clear, div; output bit_tick. Reused by the future receiver.

Test Plan:
- 8N1, baud_div = 4, send 0xA5 -> tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. frame_done pulses at cycle 40 after transfer. in_ready high again at cycle 41.
- DATA_BITS = 7, PARITY_MODE = 1 (even), STOP_BITS = 2, baud_div = 2, send 7'h41 -> start 0, data 1,0,0,0,0,0,1, parity 0, stop 1,1. Total 22 cycles.
- PARITY_MODE = 2 (odd), send 0x00 with baud_div = 1 -> parity bit 1. Each bit lasts exactly 1 cycle; frame = 11 cycles.
- in_valid held high with 0x11 then 0x22, baud_div = 3 -> exactly one IDLE cycle (tx = 1, in_ready = 1) between frames. baud_div changed to 8 mid-frame does not alter the current frame but applies to the second.
- Assert rst during DATA bit 3 of 0xFF -> next cycle tx = 1, busy = 0, in_ready = 1, no frame_done. A new frame then transmits correctly.
- baud_div = 0 with in_data 0x5A -> behaves identically to baud_div = 1 (10-cycle frame, correct bit values).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter (and the future
// receiver): FSM state encoding, parity mode constants and a parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Parity mode selector values
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Widest payload supported; narrower payloads are zero-extended, which
  // leaves the XOR reduction unchanged.
  localparam int MAX_DATA_BITS = 9;

  // Parity bit for a payload: even -> XOR of the bits, odd -> its complement.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] d,
                                       input int mode);
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-cycle counter shared by the UART transmitter and receiver.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clear     - hold the counter at 0 (e.g. while idle)
//   div       - cycles per serial bit; caller guarantees div >= 1
//   bit_tick  - high on the last cycle (count == div-1) of each bit
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_tick = (cnt_q == (div - DIV_W'(1)));
    cnt_d    = cnt_q + DIV_W'(1);
    // Clearing on the tick means the counter never wraps.
    if (clear || bit_tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input handshake.
// Frame: start(0), DATA_BITS payload LSB first, optional parity, STOP_BITS
// stop(1). Each bit lasts D = baud_div cycles (0 treated as 1), latched at
// acceptance.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   baud_div             - cycles per bit, sampled at acceptance
//   in_data/in_valid     - payload from producer
//   in_ready             - high only while idle
//   tx                   - registered serial output, idle high
//   busy                 - frame in progress
//   frame_done           - pulse on last cycle of final stop bit
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int DIV_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 bit_tick;
  logic                 last_stop;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == IDLE),
    .div      (div_q),
    .bit_tick (bit_tick)
  );

  assign last_stop  = (STOP_BITS == 1) || stop_q;
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && bit_tick && last_stop;
  assign tx         = tx_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    div_d   = div_q;
    par_d   = par_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = START;
          shift_d = in_data;
          div_d   = (baud_div == '0) ? DIV_W'(1) : baud_div;
          // Parity taken from the unshifted payload at acceptance.
          par_d   = calc_parity(MAX_DATA_BITS'(in_data), PARITY_MODE);
          idx_d   = '0;
          stop_d  = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_BITS - 1))
            state_d = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (last_stop) state_d = IDLE;
          else           stop_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next-state view so the pin changes exactly
    // on the edge that enters each bit.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      div_q   <= DIV_W'(1);
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      div_q   <= div_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

  localparam int DB    = 7;
  localparam int PM    = 1;
  localparam int SBITS = 2;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] baud_div = '0;
  logic [DB-1:0]    in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready, tx, busy, frame_done;

  uart_tx_param #(
    .DATA_BITS(DB), .PARITY_MODE(PM), .STOP_BITS(SBITS), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .tx(tx), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DB-1:0] data;
    int            d;
    longint        cyc;
  } item_t;

  item_t  sb[$];
  bit     exp_tx[$];
  bit     exp_done[$];
  bit     frame_bits[$];
  longint cyc = 0;
  int     tests = 0;
  int     fails = 0;
  bit     in_frame = 0;
  bit     gap = 0;
  bit     rst_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: start, payload LSB first, parity, stops; each bit D cycles.
  task automatic expand(input item_t it);
    int ones;
    frame_bits.delete();
    frame_bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) frame_bits.push_back(it.data[i]);
    ones = $countones(it.data);
    if (PM == 1) frame_bits.push_back((ones % 2) == 1);
    if (PM == 2) frame_bits.push_back((ones % 2) == 0);
    for (int s = 0; s < SBITS; s++) frame_bits.push_back(1'b1);
    foreach (frame_bits[k])
      for (int c = 0; c < it.d; c++) begin
        exp_tx.push_back(frame_bits[k]);
        exp_done.push_back(1'b0);
      end
    exp_done[exp_done.size()-1] = 1'b1;
  endtask

  // Monitor / scoreboard checker
  always @(negedge clk) begin
    if (rst) begin
      sb.delete(); exp_tx.delete(); exp_done.delete();
      in_frame = 0; gap = 0; rst_prev = 1;
    end else if (rst_prev) begin
      chk("reset_tx", tx, 1);
      chk("reset_busy", busy, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_frame_done", frame_done, 0);
      rst_prev = 0;
    end else if (gap) begin
      chk("gap_tx", tx, 1);
      chk("gap_in_ready", in_ready, 1);
      chk("gap_busy", busy, 0);
      chk("gap_frame_done", frame_done, 0);
      gap = 0;
    end else begin
      if (!in_frame && busy) begin
        if (sb.size() == 0) chk("unexpected_frame", busy, 0);
        else begin
          item_t it;
          it = sb.pop_front();
          chk("start_latency", 32'(cyc), 32'(it.cyc + 1));
          expand(it);
          in_frame = 1;
        end
      end
      if (in_frame) begin
        chk("tx_bit", tx, exp_tx.pop_front());
        chk("frame_done", frame_done, exp_done.pop_front());
        chk("busy", busy, 1);
        chk("in_ready_busy", in_ready, 0);
        if (exp_tx.size() == 0) begin
          in_frame = 0;
          gap = 1;
        end
      end else begin
        chk("idle_tx", tx, 1);
        chk("idle_frame_done", frame_done, 0);
      end
    end
  end

  // Drive a payload; returns one cycle after the transfer edge.
  task automatic send(input logic [DB-1:0] d, input logic [DIV_W-1:0] dv);
    int n = 0;
    item_t it;
    in_data = d; baud_div = dv; in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL in_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
      in_valid = 1'b0;
      return;
    end
    it.data = d;
    it.d    = (dv == '0) ? 1 : int'(dv);
    it.cyc  = cyc;
    sb.push_back(it);
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the frame in flight must not care.
    in_valid = 1'b0;
    in_data  = DB'($urandom);
    baud_div = DIV_W'($urandom_range(0, 15));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);

    send(7'h41, 2);          // 7E2, D=2: 22-cycle frame
    idle(3);
    send(7'h5A, 0);          // divisor 0 behaves as 1
    idle(2);
    send(7'h00, 1);
    send(7'h11, 3);          // back-to-back; next divisor applied mid-frame
    send(7'h22, 8);
    idle(4);

    // Reset during DATA bit 3 aborts the frame.
    send(7'h7F, 3);
    idle(13);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    send(7'h7F, 3);
    idle(2);

    // Reset and in_valid together: no transfer.
    in_data = 7'h33; baud_div = 2; in_valid = 1'b1; rst = 1'b1;
    idle(1);
    in_valid = 1'b0; rst = 1'b0;
    idle(3);

    for (int i = 0; i < 40; i++) begin
      send(DB'($urandom), DIV_W'($urandom_range(0, 5)));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
    end

    begin
      int n = 0;
      while ((sb.size() != 0 || in_frame || gap) && n < 2000) begin
        @(posedge clk); n++;
      end
      idle(2);
      chk("drain", sb.size() + exp_tx.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
